// File: rtl/sat_collide_n_pkg.sv
// Shared definitions for the SAT collider.
//   - coord_w / pen_w : derive coordinate width W and penetration width P_W
//   - sat_state_t     : collider FSM state encoding
//   - vtx_lsb         : bit offset of vertex k inside a packed NV*W vertex bus
package sat_collide_n_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_AXIS  = 3'd2,
    S_PROJ  = 3'd3,
    S_EVAL  = 3'd4,
    S_DONE  = 3'd5
  } sat_state_t;

  // Sign bit + integer bits + fraction bits.
  function automatic int coord_w(input int int_w, input int frac_w);
    return 1 + int_w + frac_w;
  endfunction

  // Projections are 2W+2 bits; their difference needs one more.
  function automatic int pen_w(input int w);
    return 2 * w + 3;
  endfunction

  // Vertex k of a packed coordinate bus lives at [k*w +: w].
  function automatic int vtx_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/sat_project.sv
// Combinational projection of one vertex onto an (unnormalised) axis.
//   nx, ny : W+1 bit signed axis components
//   vx, vy : W bit signed vertex coordinates
//   dot    : 2W+2 bit signed nx*vx + ny*vy (cannot overflow)
module sat_project
  import sat_collide_n_pkg::*;
#(
  parameter int W = 19
) (
  input  logic signed [W:0]     nx,
  input  logic signed [W:0]     ny,
  input  logic signed [W-1:0]   vx,
  input  logic signed [W-1:0]   vy,
  output logic signed [2*W+1:0] dot
);

  localparam int D_W = 2 * W + 2;

  logic signed [D_W-1:0] nx_e, ny_e, vx_e, vy_e;

  // Extend everything to the result width first so the products are signed
  // and full precision.
  assign nx_e = {{(D_W-W-1){nx[W]}}, nx};
  assign ny_e = {{(D_W-W-1){ny[W]}}, ny};
  assign vx_e = {{(D_W-W){vx[W-1]}}, vx};
  assign vy_e = {{(D_W-W){vy[W-1]}}, vy};

  assign dot = nx_e * vx_e + ny_e * vy_e;

endmodule

// File: rtl/sat_collide_n.sv
// Multi-cycle Separating-Axis-Theorem collider for two convex NV-gons.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    request, sampled only in IDLE
//   a_id, b_id               body tags, echoed on out_a_id / out_b_id
//   a_vx/a_vy/b_vx/b_vy      packed signed vertices, vertex k at [k*W +: W]
//   a_pos_*/b_pos_*          signed body centres (used to orient the normal)
//   busy                     high from LATCH through the last EVAL
//   done                     one-cycle pulse, results valid
//   hit, pen, best_idx       overlap flag, minimum raw overlap, winning axis
//   normal_x, normal_y       unnormalised winning axis, oriented A->B
//   out_a_id, out_b_id       latched tags
// Handshake: a start seen in IDLE is accepted and inputs are captured on that
// edge; busy then stays high until the final EVAL, done pulses for exactly one
// cycle, and results hold until the next accepted start. start outside IDLE
// has no effect.
module sat_collide_n
  import sat_collide_n_pkg::*;
#(
  parameter  int NV     = 4,
  parameter  int INT_W  = 10,
  parameter  int FRAC_W = 8,
  parameter  int ID_W   = 4,
  localparam int W      = coord_w(INT_W, FRAC_W),
  localparam int P_W    = pen_w(W),
  localparam int AX_W   = $clog2(2 * NV)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ID_W-1:0]     a_id,
  input  logic [ID_W-1:0]     b_id,
  input  logic [NV*W-1:0]     a_vx,
  input  logic [NV*W-1:0]     a_vy,
  input  logic [NV*W-1:0]     b_vx,
  input  logic [NV*W-1:0]     b_vy,
  input  logic [W-1:0]        a_pos_x,
  input  logic [W-1:0]        a_pos_y,
  input  logic [W-1:0]        b_pos_x,
  input  logic [W-1:0]        b_pos_y,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic [P_W-1:0]      pen,
  output logic [AX_W-1:0]     best_idx,
  output logic [W:0]          normal_x,
  output logic [W:0]          normal_y,
  output logic [ID_W-1:0]     out_a_id,
  output logic [ID_W-1:0]     out_b_id
);

  localparam int E_W  = W + 1;
  localparam int D_W  = 2 * W + 2;
  localparam int VI_W = $clog2(NV);
  localparam logic signed [P_W-1:0] P_ZERO = '0;
  localparam logic signed [P_W-1:0] P_MAX  = {1'b0, {(P_W-1){1'b1}}};

  sat_state_t state, state_nxt;

  // Latched operands
  logic [NV*W-1:0]     ax_r, ay_r, bx_r, by_r;
  logic signed [W-1:0] apx_r, apy_r, bpx_r, bpy_r;

  // Per-axis working state
  logic [AX_W-1:0]       axis_j;
  logic [VI_W-1:0]       vi;
  logic signed [E_W-1:0] nx_r, ny_r;
  logic                  degen_r;
  logic signed [D_W-1:0] min_a, max_a, min_b, max_b;

  // Best-so-far across axes
  logic signed [P_W-1:0] best_ov;
  logic [AX_W-1:0]       best_j;
  logic signed [E_W-1:0] best_nx, best_ny;
  logic                  any_valid;

  // Unpacked views of the latched vertices
  logic signed [W-1:0] a_x_v [NV];
  logic signed [W-1:0] a_y_v [NV];
  logic signed [W-1:0] b_x_v [NV];
  logic signed [W-1:0] b_y_v [NV];

  for (genvar k = 0; k < NV; k++) begin : g_unpack
    assign a_x_v[k] = ax_r[vtx_lsb(k, W) +: W];
    assign a_y_v[k] = ay_r[vtx_lsb(k, W) +: W];
    assign b_x_v[k] = bx_r[vtx_lsb(k, W) +: W];
    assign b_y_v[k] = by_r[vtx_lsb(k, W) +: W];
  end

  // ---------------------------------------------------------------- edge
  logic                  sel_b;
  logic [VI_W-1:0]       edge_k, edge_k1;
  logic signed [W-1:0]   v0x, v0y, v1x, v1y;
  logic signed [E_W-1:0] ex, ey;

  always_comb begin
    sel_b   = (axis_j >= AX_W'(NV));
    edge_k  = sel_b ? VI_W'(axis_j - AX_W'(NV)) : VI_W'(axis_j);
    edge_k1 = (edge_k == VI_W'(NV - 1)) ? '0 : edge_k + VI_W'(1);
    v0x     = sel_b ? b_x_v[edge_k]  : a_x_v[edge_k];
    v0y     = sel_b ? b_y_v[edge_k]  : a_y_v[edge_k];
    v1x     = sel_b ? b_x_v[edge_k1] : a_x_v[edge_k1];
    v1y     = sel_b ? b_y_v[edge_k1] : a_y_v[edge_k1];
    ex      = $signed({v1x[W-1], v1x}) - $signed({v0x[W-1], v0x});
    ey      = $signed({v1y[W-1], v1y}) - $signed({v0y[W-1], v0y});
  end

  // ---------------------------------------------------------- projection
  logic signed [D_W-1:0] dot_a, dot_b;

  sat_project #(.W(W)) u_proj_a (
    .nx (nx_r),
    .ny (ny_r),
    .vx (a_x_v[vi]),
    .vy (a_y_v[vi]),
    .dot(dot_a)
  );

  sat_project #(.W(W)) u_proj_b (
    .nx (nx_r),
    .ny (ny_r),
    .vx (b_x_v[vi]),
    .vy (b_y_v[vi]),
    .dot(dot_b)
  );

  // ---------------------------------------------------------- evaluation
  logic signed [D_W-1:0] ov_hi, ov_lo;
  logic signed [P_W-1:0] ov;
  logic                  eval_sep, eval_better, last_axis, win_valid;
  logic signed [P_W-1:0] win_ov;
  logic [AX_W-1:0]       win_j;
  logic signed [E_W-1:0] win_nx, win_ny;
  logic signed [E_W-1:0] dx, dy;
  logic signed [P_W-1:0] orient;
  logic                  flip;

  always_comb begin
    ov_hi       = (max_a < max_b) ? max_a : max_b;
    ov_lo       = (min_a > min_b) ? min_a : min_b;
    ov          = $signed({ov_hi[D_W-1], ov_hi}) - $signed({ov_lo[D_W-1], ov_lo});
    // A zero-length edge projects everything to 0; it carries no information.
    eval_sep    = !degen_r && (ov <= P_ZERO);
    eval_better = !degen_r && (ov > P_ZERO) && (ov < best_ov);
    last_axis   = (axis_j == AX_W'(2 * NV - 1));
    win_valid   = any_valid || !degen_r;
    // On separation the separating axis is reported; otherwise the best one.
    if (eval_sep || eval_better) begin
      win_ov = ov;
      win_j  = axis_j;
      win_nx = nx_r;
      win_ny = ny_r;
    end else begin
      win_ov = best_ov;
      win_j  = best_j;
      win_nx = best_nx;
      win_ny = best_ny;
    end
    dx     = $signed({bpx_r[W-1], bpx_r}) - $signed({apx_r[W-1], apx_r});
    dy     = $signed({bpy_r[W-1], bpy_r}) - $signed({apy_r[W-1], apy_r});
    orient = $signed({{(P_W-E_W){win_nx[E_W-1]}}, win_nx}) * $signed({{(P_W-E_W){dx[E_W-1]}}, dx})
           + $signed({{(P_W-E_W){win_ny[E_W-1]}}, win_ny}) * $signed({{(P_W-E_W){dy[E_W-1]}}, dy});
    flip   = (orient < P_ZERO);
  end

  // ---------------------------------------------------------- next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_AXIS;
      S_AXIS:  state_nxt = S_PROJ;
      S_PROJ:  if (vi == VI_W'(NV - 1)) state_nxt = S_EVAL;
      S_EVAL:  state_nxt = (eval_sep || last_axis) ? S_DONE : S_AXIS;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_LATCH) || (state == S_AXIS) ||
                (state == S_PROJ)  || (state == S_EVAL);
  assign done = (state == S_DONE);

  // ---------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ax_r      <= '0;
      ay_r      <= '0;
      bx_r      <= '0;
      by_r      <= '0;
      apx_r     <= '0;
      apy_r     <= '0;
      bpx_r     <= '0;
      bpy_r     <= '0;
      axis_j    <= '0;
      vi        <= '0;
      nx_r      <= '0;
      ny_r      <= '0;
      degen_r   <= 1'b0;
      min_a     <= '0;
      max_a     <= '0;
      min_b     <= '0;
      max_b     <= '0;
      best_ov   <= P_MAX;
      best_j    <= '0;
      best_nx   <= '0;
      best_ny   <= '0;
      any_valid <= 1'b0;
      hit       <= 1'b0;
      pen       <= '0;
      best_idx  <= '0;
      normal_x  <= '0;
      normal_y  <= '0;
      out_a_id  <= '0;
      out_b_id  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            ax_r     <= a_vx;
            ay_r     <= a_vy;
            bx_r     <= b_vx;
            by_r     <= b_vy;
            apx_r    <= a_pos_x;
            apy_r    <= a_pos_y;
            bpx_r    <= b_pos_x;
            bpy_r    <= b_pos_y;
            out_a_id <= a_id;
            out_b_id <= b_id;
            hit      <= 1'b0;
            pen      <= '0;
            best_idx <= '0;
            normal_x <= '0;
            normal_y <= '0;
          end
        end
        S_LATCH: begin
          axis_j    <= '0;
          best_ov   <= P_MAX;
          best_j    <= '0;
          best_nx   <= '0;
          best_ny   <= '0;
          any_valid <= 1'b0;
        end
        S_AXIS: begin
          nx_r    <= -ey;
          ny_r    <= ex;
          degen_r <= (ex == '0) && (ey == '0);
          vi      <= '0;
        end
        S_PROJ: begin
          if (vi == '0) begin
            min_a <= dot_a;
            max_a <= dot_a;
            min_b <= dot_b;
            max_b <= dot_b;
          end else begin
            if (dot_a < min_a) min_a <= dot_a;
            if (dot_a > max_a) max_a <= dot_a;
            if (dot_b < min_b) min_b <= dot_b;
            if (dot_b > max_b) max_b <= dot_b;
          end
          vi <= vi + VI_W'(1);
        end
        S_EVAL: begin
          // Strict less-than keeps the earlier axis on ties.
          if (eval_better) begin
            best_ov <= ov;
            best_j  <= axis_j;
            best_nx <= nx_r;
            best_ny <= ny_r;
          end
          if (!degen_r) any_valid <= 1'b1;
          axis_j <= axis_j + AX_W'(1);
          if (eval_sep || last_axis) begin
            hit <= !eval_sep && win_valid;
            if (win_valid) begin
              pen      <= win_ov;
              best_idx <= win_j;
              normal_x <= flip ? -win_nx : win_nx;
              normal_y <= flip ? -win_ny : win_ny;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/sat_collide_n.md
Name: sat_collide_n

Overview:
- Parametrised, multi-cycle Separating-Axis-Theorem collider for two convex NV-gon bodies in signed fixed point.
- Sits between the broad-phase pair selector and the impulse solver. Accepts one body pair per start pulse.
- Returns hit, minimum penetration, the axis index that produced it, and the contact normal oriented from A to B.
- Generalises the fixed 4-vertex collider in vertex count and number format. Adds a start/busy/done handshake, early exit on the first separating axis, and normal orientation.

Parameters:
- NV, 4: vertices per polygon (>=3, convex, consistent winding).
- INT_W, 10: integer bits.
- FRAC_W, 8: fraction bits. Coordinate width W = 1+INT_W+FRAC_W (19).
- ID_W, 4: body tag width.
- Derived: P_W = 2W+3; AX_W = clog2(2*NV).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only in IDLE
- a_id, b_id  in  ID_W  body tags; latched, echoed on out_a_id/out_b_id
- a_vx, a_vy, b_vx, b_vy  in  NV*W  packed signed vertices; vertex k at [k*W +: W]
- a_pos_x, a_pos_y, b_pos_x, b_pos_y  in  W  signed body centres
- busy  out  1  high from LATCH through EVAL of the last axis processed
- done  out  1  one-cycle pulse when results are valid
- hit  out  1  overlap on every non-degenerate axis
- pen  out  P_W  signed minimum unnormalised overlap
- best_idx  out  AX_W  winning axis; 0..NV-1 = edges of A, NV..2NV-1 = edges of B
- normal_x, normal_y  out  W+1  signed unnormalised winning axis, oriented A->B
- out_a_id, out_b_id  out  ID_W  latched tags

Behaviour:
- States: IDLE, LATCH, AXIS, PROJ, EVAL, DONE.
- Reset: state IDLE. All outputs 0. Reset mid-operation aborts the pair; done does not pulse.
- IDLE: start=1 -> LATCH. LATCH captures all inputs, so inputs may change afterwards. start while not IDLE is ignored.
- AXIS (axis j): take edge e = v[(k+1) mod NV] - v[k] from the A or B set (W+1 bits). Axis n = (-e_y, e_x).
- PROJ: NV cycles. Cycle i computes n·A[i] and n·B[i] (2W+2 bits each) and updates running minA/maxA/minB/maxB.
- EVAL: ov = min(maxA,maxB) - max(minA,minB), P_W bits.
  - Degenerate axis (e == 0): skip; not eligible for best.
  - ov <= 0: separation. Touching counts as separated. hit=0, go to DONE.
  - Otherwise, if ov < best: record ov, j and n. Ties keep the lower j.
  - Next axis, or DONE after j = 2NV-1.
- DONE: done=1 for one cycle, busy=0.
  - hit=1 if no separating axis was found and at least one axis was valid.
  - If dot(n, bpos - apos) < 0, negate the normal.
  - Outputs hold until the next LATCH, which clears hit/pen/best_idx/normal.
- Latency, counting the start cycle as 0:
  - No separation: done in cycle 2 + 2NV(NV+2), i.e. 50 for NV=4.
  - Separation found at axis j: done in cycle 2 + (j+1)(NV+2).
- Overlap is not normalised by |n|; the solver normalises. Comparisons across axes are on raw values.

Decomposition:
- Shared package: W/P_W derivation functions, the state enum, and the vertex unpack helper.
- One sub-module, sat_project: a combinational dot product of one vertex with the axis, instantiated twice (A and B paths).

Test Plan:
- A = square (150,50),(50,50),(50,150),(150,150); B = (200,0),(100,0),(100,100),(200,100) in 10.8 format; centres (100,100), (150,50); ids 0/0. Expect:
  - done at cycle 50, hit=1
  - pen = 327680000, best_idx=0 (tie-break)
  - normal = (0,-25600)
- Same pair with A and B swapped. Expect hit=1, pen=327680000, best_idx=0, normal flipped to (0,+25600).
- B shifted +200 px in x. Expect separation on axis 1, done at cycle 14, hit=0.
- B shifted +50 px in x (edges touch, overlap 0). Expect hit=0, done at cycle 14.
- Assert rst at cycle 20 of a colliding run. Expect busy=0 next cycle, no done pulse, hit=0. A fresh start then completes normally at cycle 50.
- start held high throughout a run plus B with a duplicated vertex (zero edge). Expect only one run accepted, degenerate axis skipped, and best_idx never equal to the degenerate axis.
